display_hdmi_line_fetch_ctrl: RTL and testbench

- Sequences per-line prefetch of packed pixel words from frame memory into the HDMI display line buffer.
- Watches display timing (vs/de) and issues burst read requests to the memory read port.
- Streams returned words out as indexed line-buffer writes (x, valid, data) for the downstream unpack stage.
- Flags underrun when display timing outpaces memory.

---
 rtl/display_hdmi_line_fetch_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_display_hdmi_line_fetch_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/display_hdmi_line_fetch_ctrl.sv
// Per-line prefetch sequencer: converts display vs/de timing into burst reads
// from frame memory and streams returned words into the HDMI line buffer.
module display_hdmi_line_fetch_ctrl #(
  parameter int PIXEL_BIT  = 32,
  parameter int PACK_BIT   = 64,
  parameter int FIFO_WIDTH = 10,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BURST_LEN  = 16
) (
  input  logic                  in_pclk,
  input  logic                  in_rst,
  input  logic                  in_vs,
  input  logic                  in_de,
  input  logic [31:0]           in_frame_base,
  output logic                  out_rd_req,
  output logic [31:0]           out_rd_addr,
  output logic [7:0]            out_rd_len,
  input  logic                  in_rd_ack,
  input  logic                  in_rd_valid,
  input  logic [PACK_BIT-1:0]   in_rd_data,
  output logic [FIFO_WIDTH-1:0] out_x,
  output logic [FIFO_WIDTH-1:0] out_y,
  output logic                  out_valid,
  output logic [PACK_BIT-1:0]   out_data,
  output logic                  out_busy,
  output logic                  out_underrun
);

  localparam int WPL   = H_ACTIVE * PIXEL_BIT / PACK_BIT;
  localparam int BYTES = PACK_BIT / 8;

  localparam logic [31:0]           WPL_W   = 32'(WPL);
  localparam logic [31:0]           BYTES_W = 32'(BYTES);
  localparam logic [31:0]           BL_W    = 32'(BURST_LEN);
  localparam logic [31:0]           VACT_W  = 32'(V_ACTIVE);
  localparam logic [FIFO_WIDTH-1:0] W_ZERO  = {FIFO_WIDTH{1'b0}};
  localparam logic [FIFO_WIDTH-1:0] W_ONE   = FIFO_WIDTH'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [FIFO_WIDTH-1:0] line_r, line_s;
  logic [FIFO_WIDTH-1:0] wcnt_r, wcnt_s;
  logic [7:0]            beat_r, beat_s, blen_r, blen_s, beat_inc_s;
  logic [31:0]           base_r, base_s;
  logic                  pending_r, pending_s;
  logic                  underrun_s, wr_s;
  logic                  vs_d_r, de_d_r;
  logic                  vs_rise_s, de_trig_s, line_ok_s, last_word_s;
  logic [31:0]           word_idx_s, rem_s, addr_s;
  logic [7:0]            len_s;

  // A de fall only counts as a trigger while the frame still has lines left.
  assign vs_rise_s   = in_vs & ~vs_d_r;
  assign line_ok_s   = (32'(line_r) < VACT_W);
  assign de_trig_s   = ~in_de & de_d_r & line_ok_s;
  assign beat_inc_s  = beat_r + 8'd1;
  assign last_word_s = ((32'(wcnt_r) + 32'd1) >= WPL_W);

  // Request address/length are derived from the values the FSM is moving to.
  assign word_idx_s  = 32'(line_s) * WPL_W + 32'(wcnt_s);
  assign addr_s      = base_s + word_idx_s * BYTES_W;
  assign rem_s       = WPL_W - 32'(wcnt_s);
  assign len_s       = 8'((rem_s > BL_W) ? BL_W : rem_s);

  // Next-state, counters and write strobe; a vs rise restarts the frame from any state.
  always_comb begin
    state_s    = state_r;
    line_s     = line_r;
    wcnt_s     = wcnt_r;
    beat_s     = beat_r;
    blen_s     = blen_r;
    base_s     = base_r;
    pending_s  = pending_r;
    underrun_s = out_underrun;
    wr_s       = 1'b0;

    if (vs_rise_s) begin
      base_s    = in_frame_base;
      line_s    = W_ZERO;
      wcnt_s    = W_ZERO;
      pending_s = (state_r != ST_IDLE);
    end else if (de_trig_s && (state_r != ST_IDLE)) begin
      underrun_s = 1'b1;
      pending_s  = 1'b1;
    end else begin
      underrun_s = out_underrun;
    end

    case (state_r)
      ST_IDLE: begin
        if (vs_rise_s) begin
          state_s = ST_REQ;
        end else if (pending_r) begin
          // A fresh trigger landing on the queued start takes the single pending slot.
          pending_s  = de_trig_s;
          underrun_s = out_underrun | de_trig_s;
          state_s    = line_ok_s ? ST_REQ : ST_IDLE;
        end else if (de_trig_s) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (in_rd_ack) begin
          beat_s  = 8'd0;
          blen_s  = out_rd_len;
          state_s = vs_rise_s ? ST_DRAIN : ST_DATA;
        end else if (vs_rise_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_DATA: begin
        if (in_rd_valid) begin
          beat_s = beat_inc_s;
          if (vs_rise_s) begin
            state_s = (beat_inc_s == blen_r) ? ST_IDLE : ST_DRAIN;
          end else begin
            wr_s   = 1'b1;
            wcnt_s = wcnt_r + W_ONE;
            if (beat_inc_s != blen_r) begin
              state_s = ST_DATA;
            end else if (!last_word_s) begin
              state_s = ST_REQ;
            end else begin
              state_s = ST_IDLE;
              line_s  = line_r + W_ONE;
              wcnt_s  = W_ZERO;
            end
          end
        end else if (vs_rise_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_DRAIN: begin
        if (in_rd_valid) begin
          beat_s  = beat_inc_s;
          state_s = (beat_inc_s == blen_r) ? ST_IDLE : ST_DRAIN;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters, edge detectors and all registered outputs.
  always_ff @(posedge in_pclk) begin
    if (in_rst) begin
      state_r      <= ST_IDLE;
      line_r       <= W_ZERO;
      wcnt_r       <= W_ZERO;
      beat_r       <= 8'd0;
      blen_r       <= 8'd0;
      base_r       <= 32'd0;
      pending_r    <= 1'b0;
      vs_d_r       <= 1'b0;
      de_d_r       <= 1'b0;
      out_rd_req   <= 1'b0;
      out_rd_addr  <= 32'd0;
      out_rd_len   <= 8'd0;
      out_x        <= W_ZERO;
      out_y        <= W_ZERO;
      out_valid    <= 1'b0;
      out_data     <= {PACK_BIT{1'b0}};
      out_busy     <= 1'b0;
      out_underrun <= 1'b0;
    end else begin
      state_r      <= state_s;
      line_r       <= line_s;
      wcnt_r       <= wcnt_s;
      beat_r       <= beat_s;
      blen_r       <= blen_s;
      base_r       <= base_s;
      pending_r    <= pending_s;
      vs_d_r       <= in_vs;
      de_d_r       <= in_de;
      out_rd_req   <= (state_s == ST_REQ);
      if (state_s == ST_REQ) begin
        out_rd_addr <= addr_s;
        out_rd_len  <= len_s;
        out_y       <= line_s;
      end else begin
        out_rd_addr <= 32'd0;
        out_rd_len  <= 8'd0;
      end
      out_valid    <= wr_s;
      if (wr_s) begin
        out_x    <= wcnt_r;
        out_data <= in_rd_data;
      end
      out_busy     <= (state_s != ST_IDLE);
      out_underrun <= underrun_s;
    end
  end

endmodule

// File: tb/tb_display_hdmi_line_fetch_ctrl.sv
// Directed bench for display_hdmi_line_fetch_ctrl: 20 words/line, 8-word bursts,
// 4 lines per frame, with a bench-side memory responder driven step by step.
module tb_display_hdmi_line_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, vs, de, ack, rvalid;
  logic [31:0] base;
  logic [63:0] rdata;

  logic        out_rd_req, out_valid, out_busy, out_underrun;
  logic [31:0] out_rd_addr;
  logic [7:0]  out_rd_len;
  logic [9:0]  out_x, out_y;
  logic [63:0] out_data;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  display_hdmi_line_fetch_ctrl #(
    .PIXEL_BIT(32), .PACK_BIT(64), .FIFO_WIDTH(10),
    .H_ACTIVE(40), .V_ACTIVE(4), .BURST_LEN(8)
  ) dut (
    .in_pclk(clk), .in_rst(rst), .in_vs(vs), .in_de(de),
    .in_frame_base(base),
    .out_rd_req(out_rd_req), .out_rd_addr(out_rd_addr), .out_rd_len(out_rd_len),
    .in_rd_ack(ack), .in_rd_valid(rvalid), .in_rd_data(rdata),
    .out_x(out_x), .out_y(out_y), .out_valid(out_valid), .out_data(out_data),
    .out_busy(out_busy), .out_underrun(out_underrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [63:0] pat(input int y, input int x);
    return 64'hC0DE_0000_0000_0000 | (64'(y) << 16) | 64'(x);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},  64'(out_rd_req),   64'd0);
    chk({tag, "_addr"}, 64'(out_rd_addr),  64'd0);
    chk({tag, "_len"},  64'(out_rd_len),   64'd0);
    chk({tag, "_x"},    64'(out_x),        64'd0);
    chk({tag, "_y"},    64'(out_y),        64'd0);
    chk({tag, "_vld"},  64'(out_valid),    64'd0);
    chk({tag, "_data"}, out_data,          64'd0);
    chk({tag, "_busy"}, 64'(out_busy),     64'd0);
    chk({tag, "_und"},  64'(out_underrun), 64'd0);
  endtask

  // Wait for a request, check it, ack after dly cycles, then return nb beats back-to-back.
  task automatic serve(input logic [31:0] addr, input int len, input int dly,
                       input int y, input int x0, input int nb);
    int waited = 0;
    while (!out_rd_req && waited < 20) begin
      tick();
      waited++;
    end
    chk("req_seen", 64'(out_rd_req), 64'd1);
    if (!out_rd_req) return;
    chk("rd_addr",  64'(out_rd_addr), 64'(addr));
    chk("rd_len",   64'(out_rd_len),  64'(len));
    chk("busy_req", 64'(out_busy),    64'd1);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("req_hold", 64'({out_rd_req, out_rd_addr}), 64'({1'b1, addr}));
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("req_drop",  64'(out_rd_req), 64'd0);
    chk("no_early_wr", 64'(out_valid), 64'd0);
    for (int i = 0; i < nb; i++) begin
      rvalid = 1'b1;
      rdata  = pat(y, x0 + i);
      tick();
      chk("wr_valid", 64'(out_valid), 64'd1);
      chk("wr_x",     64'(out_x),     64'(x0 + i));
      chk("wr_y",     64'(out_y),     64'(y));
      chk("wr_data",  out_data,       pat(y, x0 + i));
    end
    rvalid = 1'b0;
  endtask

  task automatic fetch_line(input logic [31:0] a0, input int y);
    serve(a0,          8, 2, y, 0,  8);
    serve(a0 + 32'h40, 8, 2, y, 8,  8);
    serve(a0 + 32'h80, 4, 2, y, 16, 4);
  endtask

  task automatic pulse_de();
    de = 1'b1;
    tick();
    de = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; vs = 1'b0; de = 1'b0; base = 32'd0;
    ack = 1'b0; rvalid = 1'b0; rdata = 64'd0;
    tick();
    tick();
    chk_zero("rst");
    rst = 1'b0;
    tick();
    chk_zero("post_rst");

    // Frame start prefetches line 0 as three bursts.
    base = 32'h1000;
    vs   = 1'b1;
    tick();
    vs   = 1'b0;
    fetch_line(32'h1000, 0);
    chk("busy_line0_done", 64'(out_busy), 64'd0);
    tick();
    chk("idle_no_req", 64'(out_rd_req), 64'd0);

    // First de fall fetches line 1.
    pulse_de();
    fetch_line(32'h10A0, 1);
    chk("busy_line1_done", 64'(out_busy), 64'd0);
    chk("no_underrun_yet", 64'(out_underrun), 64'd0);

    // Two extra de falls while line 2 waits on a slow ack.
    pulse_de();
    chk("slow_req", 64'(out_rd_req), 64'd1);
    chk("slow_addr", 64'(out_rd_addr), 64'h1140);
    pulse_de();
    chk("underrun_set", 64'(out_underrun), 64'd1);
    pulse_de();
    serve(32'h1140, 8, 190, 2, 0,  8);
    serve(32'h1180, 8, 2,   2, 8,  8);
    serve(32'h11C0, 4, 2,   2, 16, 4);
    chk("idle_before_pending", 64'(out_busy), 64'd0);
    chk("no_req_in_idle", 64'(out_rd_req), 64'd0);
    tick();
    chk("pending_req", 64'(out_rd_req), 64'd1);
    chk("pending_addr", 64'(out_rd_addr), 64'h11E0);
    fetch_line(32'h11E0, 3);
    chk("busy_line3_done", 64'(out_busy), 64'd0);
    repeat (5) tick();
    chk("second_trig_dropped", 64'(out_rd_req), 64'd0);

    // Frame complete: further de falls issue nothing.
    pulse_de();
    repeat (5) tick();
    chk("frame_done_no_req", 64'(out_rd_req), 64'd0);
    chk("frame_done_idle", 64'(out_busy), 64'd0);
    chk("underrun_sticky", 64'(out_underrun), 64'd1);

    // vs rise after 3 of 8 beats: the rest are drained silently.
    base = 32'h2000;
    vs   = 1'b1;
    tick();
    vs   = 1'b0;
    serve(32'h2000, 8, 2, 0, 0, 3);
    base = 32'h8000;
    vs   = 1'b1;
    tick();
    vs   = 1'b0;
    chk("drain_busy", 64'(out_busy), 64'd1);
    chk("drain_no_req", 64'(out_rd_req), 64'd0);
    for (int i = 0; i < 5; i++) begin
      rvalid = 1'b1;
      rdata  = 64'hDEAD_0000_0000_0000 | 64'(i);
      tick();
      chk("drain_no_wr", 64'(out_valid), 64'd0);
    end
    rvalid = 1'b0;
    serve(32'h8000, 8, 2, 0, 0, 3);

    // Reset mid-burst, then stray beats must be ignored.
    rst    = 1'b1;
    rvalid = 1'b1;
    rdata  = 64'h1234_5678_9ABC_DEF0;
    tick();
    chk_zero("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stray_no_wr", 64'(out_valid), 64'd0);
      chk("stray_idle",  64'(out_busy),  64'd0);
    end
    rvalid = 1'b0;
    tick();
    chk("stray_no_req", 64'(out_rd_req), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
